// File: rtl/rtc_adapter_pkg.sv
// -----------------------------------------------------------------------------
// rtc_adapter_pkg
// Shared constants and types for the stopwatch digit-scan stage: digit width,
// the per-digit nibble type and the active-low 7-segment codes (bit 0 = CA).
// -----------------------------------------------------------------------------
package rtc_adapter_pkg;

    localparam int DIGIT_WIDTH = 4;

    typedef logic [DIGIT_WIDTH-1:0] digit_t;

    // All cathodes off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes for hex digits 0-F.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/rtc_adapter_seg_decode.sv
// -----------------------------------------------------------------------------
// rtc_adapter_seg_decode
// Combinational hex nibble to active-low 7-segment code.
//   digit_i : 4-bit hex value
//   seg_o   : cathodes CA..CG, bit 0 = CA, active-low
// -----------------------------------------------------------------------------
module rtc_adapter_seg_decode
    import rtc_adapter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Hex-to-segment lookup.
    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/rtc_adapter_scan.sv
// -----------------------------------------------------------------------------
// rtc_adapter_scan
// Multiplexed 7-segment digit scanner driven by the 1 ms adapter clock.
// Every rising edge of i_intclk advances the scan by one digit; stopwatch
// data is double-buffered and the live buffer is swapped only at frame
// boundaries so a frame never shows a mix of old and new digits.
//   i_sclk        system clock
//   i_reset_n     async active-low reset
//   i_intclk      1 ms square wave (asynchronous to i_sclk)
//   i_digits      digit nibbles, [3:0] = digit 0 (rightmost)
//   i_dp          per-digit decimal point request, active-high
//   i_blank_lz    live leading-zero blanking enable
//   i_load        one-cycle strobe capturing i_digits/i_dp into staging
//   o_an          digit anodes, active-low
//   o_seg         cathodes CA..CG, active-low
//   o_dp          decimal point cathode, active-low
//   o_frame_done  one-cycle pulse at every frame boundary
// -----------------------------------------------------------------------------
module rtc_adapter_scan
    import rtc_adapter_pkg::digit_t;
    import rtc_adapter_pkg::SEG_BLANK;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                              i_sclk,
    input  logic                              i_reset_n,
    input  logic                              i_intclk,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]             i_dp,
    input  logic                              i_blank_lz,
    input  logic                              i_load,
    output logic [NUM_DIGITS-1:0]             o_an,
    output logic [6:0]                        o_seg,
    output logic                              o_dp,
    output logic                              o_frame_done
);

    localparam int                    IDX_W    = 3;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // Tick synchronizer.
    logic intclk_meta_q, intclk_sync_q, intclk_hist_q;
    logic tick_s, boundary_s;

    // Scan state. started_q stays low from reset until the first tick so the
    // display remains dark until scanning really begins at digit 0.
    logic [IDX_W-1:0] index_q, index_d;
    logic             started_q, started_d;

    // Double buffer.
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] stage_dig_q, stage_dig_d;
    logic [NUM_DIGITS-1:0]             stage_dp_q, stage_dp_d;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]             act_dp_q, act_dp_d;
    logic                              pending_q, pending_d;

    // Output path.
    digit_t                act_arr_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero_s;
    logic                  zero_run_s;
    digit_t                sel_digit_s;
    logic [6:0]            seg_code_s;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic                  frame_done_d, frame_done_q;

    // Two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            intclk_meta_q <= 1'b0;
            intclk_sync_q <= 1'b0;
            intclk_hist_q <= 1'b0;
        end else begin
            intclk_meta_q <= i_intclk;
            intclk_sync_q <= intclk_meta_q;
            intclk_hist_q <= intclk_sync_q;
        end
    end

    assign tick_s     = intclk_sync_q & ~intclk_hist_q;
    assign boundary_s = tick_s & started_q & (index_q == LAST_IDX);

    // Next-state for scan index, staging/active buffers and pending flag.
    always_comb begin
        index_d     = index_q;
        started_d   = started_q;
        stage_dig_d = stage_dig_q;
        stage_dp_d  = stage_dp_q;
        act_dig_d   = act_dig_q;
        act_dp_d    = act_dp_q;
        pending_d   = pending_q;

        if (tick_s) begin
            if (!started_q) begin
                // First tick after reset lights digit 0 without advancing.
                started_d = 1'b1;
                index_d   = {IDX_W{1'b0}};
            end else if (index_q == LAST_IDX) begin
                index_d = {IDX_W{1'b0}};
            end else begin
                index_d = index_q + 3'd1;
            end
        end else begin
            index_d = index_q;
        end

        // Swap uses the pre-load staging value so a coincident load lands
        // one frame later.
        if (boundary_s && pending_q) begin
            act_dig_d = stage_dig_q;
            act_dp_d  = stage_dp_q;
        end else begin
            act_dig_d = act_dig_q;
            act_dp_d  = act_dp_q;
        end

        if (i_load) begin
            stage_dig_d = i_digits;
            stage_dp_d  = i_dp;
            pending_d   = 1'b1;
        end else if (boundary_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Scan and buffer state registers.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            index_q     <= {IDX_W{1'b0}};
            started_q   <= 1'b0;
            stage_dig_q <= '0;
            stage_dp_q  <= '0;
            act_dig_q   <= '0;
            act_dp_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            index_q     <= index_d;
            started_q   <= started_d;
            stage_dig_q <= stage_dig_d;
            stage_dp_q  <= stage_dp_d;
            act_dig_q   <= act_dig_d;
            act_dp_q    <= act_dp_d;
            pending_q   <= pending_d;
        end
    end

    // Split the active vector into nibbles.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            act_arr_s[k] = act_dig_q[k*DIGIT_WIDTH +: DIGIT_WIDTH];
        end
    end

    // Leading-zero mask: digit k blanks when it and every digit above it are
    // zero; digit 0 never blanks.
    always_comb begin
        lead_zero_s = '0;
        zero_run_s  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s     = zero_run_s & (act_arr_s[k] == 4'h0);
            lead_zero_s[k] = zero_run_s & (k != 0);
        end
    end

    assign sel_digit_s = act_arr_s[index_q];

    rtc_adapter_seg_decode u_seg_decode (
        .digit_i (sel_digit_s),
        .seg_o   (seg_code_s)
    );

    // Output next-state from active buffer, scan index and live blanking.
    always_comb begin
        an_d         = {NUM_DIGITS{1'b1}};
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_done_d = boundary_s;
        if (started_q) begin
            an_d = ~(AN_ONE << index_q);
            dp_d = ~act_dp_q[index_q];
            if (i_blank_lz && lead_zero_s[index_q]) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_code_s;
            end
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            an_q         <= {NUM_DIGITS{1'b1}};
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_an         = an_q;
    assign o_seg        = seg_q;
    assign o_dp         = dp_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_rtc_adapter_scan.sv
// -----------------------------------------------------------------------------
// tb_rtc_adapter_scan
// Directed bench for the digit scanner: reset state, scan order, double
// buffering, leading-zero blanking, decimal points, coincident load and
// mid-scan reset.
// -----------------------------------------------------------------------------
module tb_rtc_adapter_scan;

    logic        clk;
    logic        rst_n;
    logic        intclk;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        blank;
    logic        load;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        fd;

    int n_cmp;
    int n_err;

    // Values captured by scan_edge.
    logic [7:0] an_s;
    logic [6:0] seg_s;
    logic       dp_s;
    logic       fd_mid_s;
    logic       fd_after_s;

    logic [6:0] seg_new [8];

    rtc_adapter_scan #(.NUM_DIGITS(8), .DIGIT_WIDTH(4)) dut (
        .i_sclk       (clk),
        .i_reset_n    (rst_n),
        .i_intclk     (intclk),
        .i_digits     (digits),
        .i_dp         (dp),
        .i_blank_lz   (blank),
        .i_load       (load),
        .o_an         (an),
        .o_seg        (seg),
        .o_dp         (dpo),
        .o_frame_done (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One i_intclk rising edge; optionally pulses i_load so it is captured on
    // the same clock edge that the tick acts on.
    task automatic scan_edge(input bit with_load, input logic [31:0] ld_dig, input logic [7:0] ld_dp);
        @(negedge clk) intclk = 1'b1;
        @(posedge clk);               // E0
        @(posedge clk);               // E1: tick now high
        if (with_load) begin
            #1;
            load   = 1'b1;
            digits = ld_dig;
            dp     = ld_dp;
        end
        @(posedge clk);               // E2: index/frame_done update
        #1;
        load     = 1'b0;
        fd_mid_s = fd;
        @(posedge clk);               // E3: outputs update
        #1;
        an_s       = an;
        seg_s      = seg;
        dp_s       = dpo;
        fd_after_s = fd;
        @(negedge clk) intclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_pulse(input logic [31:0] ld_dig, input logic [7:0] ld_dp);
        @(negedge clk);
        load   = 1'b1;
        digits = ld_dig;
        dp     = ld_dp;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic chk_scan(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp, input logic e_fd);
        chk($sformatf("%s_an", tag), {24'h0, an_s}, {24'h0, e_an});
        chk($sformatf("%s_seg", tag), {25'h0, seg_s}, {25'h0, e_seg});
        chk($sformatf("%s_dp", tag), {31'h0, dp_s}, {31'h0, e_dp});
        chk($sformatf("%s_fd", tag), {31'h0, fd_mid_s}, {31'h0, e_fd});
        chk($sformatf("%s_fd_one_cycle", tag), {31'h0, fd_after_s}, 32'h0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        intclk = 1'b0;
        load   = 1'b0;
        blank  = 1'b0;
        digits = 32'h0;
        dp     = 8'h0;
        seg_new[0] = 7'h19; seg_new[1] = 7'h30; seg_new[2] = 7'h24; seg_new[3] = 7'h79;
        seg_new[4] = 7'h7F; seg_new[5] = 7'h7F; seg_new[6] = 7'h7F; seg_new[7] = 7'h7F;

        // Reset state.
        #23;
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dpo}, 32'h1);
        chk("rst_fd", {31'h0, fd}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_an", {24'h0, an}, 32'hFF);

        // First frame with all-zero active buffer.
        for (int i = 0; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("f0_d%0d", i), ~(8'h01 << i), 7'h40, 1'b1, 1'b0);
        end
        scan_edge(1'b0, 32'h0, 8'h0);
        chk_scan("f0_wrap", 8'hFE, 7'h40, 1'b1, 1'b1);

        // Mid-frame load with blanking: old (zero) data until the boundary.
        blank = 1'b1;
        load_pulse(32'h0000_1234, 8'h00);
        for (int i = 1; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("old_d%0d", i), ~(8'h01 << i), 7'h7F, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("new_d%0d", i), ~(8'h01 << i), seg_new[i], 1'b1, (i == 0));
        end

        // Decimal point on blanked digit 2.
        load_pulse(32'h0, 8'h04);
        for (int i = 0; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("dp_d%0d", i), ~(8'h01 << i), (i == 0) ? 7'h40 : 7'h7F,
                     (i == 2) ? 1'b0 : 1'b1, (i == 0));
        end

        // Two loads before a boundary: latest wins; one frame_done per frame.
        blank = 1'b0;
        load_pulse(32'h1111_1111, 8'h00);
        load_pulse(32'h2222_2222, 8'h00);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                scan_edge(1'b0, 32'h0, 8'h0);
                chk_scan($sformatf("dbl_f%0d_d%0d", f, i), ~(8'h01 << i), 7'h24, 1'b1, (i == 0));
            end
        end

        // Load coincident with a boundary tick.
        load_pulse(32'h3333_3333, 8'h00);
        scan_edge(1'b1, 32'h4444_4444, 8'h00);
        chk_scan("coin_n1_d0", 8'hFE, 7'h30, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("coin_n1_d%0d", i), ~(8'h01 << i), 7'h30, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
            chk_scan($sformatf("coin_n2_d%0d", i), ~(8'h01 << i), 7'h19, 1'b1, (i == 0));
        end

        // Reset mid-scan at index 5.
        for (int i = 0; i < 6; i++) begin
            scan_edge(1'b0, 32'h0, 8'h0);
        end
        chk("pre_rst_an", {24'h0, an_s}, 32'hDF);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {24'h0, an}, 32'hFF);
        chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
        chk("mid_rst_dp", {31'h0, dpo}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_an", {24'h0, an}, 32'hFF);
        scan_edge(1'b0, 32'h0, 8'h0);
        chk_scan("post_rst_d0", 8'hFE, 7'h40, 1'b1, 1'b0);
        scan_edge(1'b0, 32'h0, 8'h0);
        chk_scan("post_rst_d1", 8'hFD, 7'h40, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
